ifu: RTL

Instruction fetch unit: the consumer of the program counter. On every PC update strobe, and once automatically after reset, it reads the current `pc`, issues one read on the instruction-memory read channel (AXI4-Lite AR/R subset), and holds the returned instruction and its PC on a valid/ready output toward decode. It sits between the PC register and the IDU in the single/multi-cycle core, and it is the only master on the instruction bus.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_OUT
  } ifu_state_e;

  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic       CAUSE_MISALIGN = 1'b0;
  localparam logic       CAUSE_BUS_ERR  = 1'b1;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one AXI4-Lite AR/R read per PC update, result held toward decode.
// Optional IFU_FAULT_EN adds misaligned-PC and bus-error fault reporting.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic             pc_update,
  output logic [WIDTH-1:0] araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic             fault,
  output logic             fault_cause
);

  ifu_state_e       state_q, state_d;
  logic             arvalid_q, arvalid_d;
  logic             rready_q, rready_d;
  logic             inst_valid_q, inst_valid_d;
  logic             fault_q, fault_d;
  logic             fault_cause_q, fault_cause_d;
  logic [31:0]      inst_q, inst_d;
  logic [WIDTH-1:0] inst_pc_q, inst_pc_d;

  always_comb begin
    state_d       = state_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    inst_valid_d  = inst_valid_q;
    fault_d       = fault_q;
    fault_cause_d = fault_cause_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;

    unique case (state_q)
      S_BOOT: begin
`ifdef IFU_FAULT_EN
        if (pc_misaligned(pc[1:0])) begin
          state_d       = S_OUT;
          inst_valid_d  = 1'b1;
          fault_d       = 1'b1;
          fault_cause_d = CAUSE_MISALIGN;
          inst_d        = '0;
          inst_pc_d     = pc;
        end else begin
          state_d   = S_ADDR;
          arvalid_d = 1'b1;
        end
`else
        state_d   = S_ADDR;
        arvalid_d = 1'b1;
`endif
      end

      S_IDLE: begin
        if (pc_update) begin
          state_d   = S_ADDR;
          arvalid_d = 1'b1;
        end
      end

      S_ADDR: begin
`ifdef IFU_FAULT_EN
        // The new pc only becomes visible here after an update, so alignment is judged in ADDR.
        if (pc_misaligned(pc[1:0])) begin
          state_d       = S_OUT;
          arvalid_d     = 1'b0;
          inst_valid_d  = 1'b1;
          fault_d       = 1'b1;
          fault_cause_d = CAUSE_MISALIGN;
          inst_d        = '0;
          inst_pc_d     = pc;
        end else if (arready) begin
          state_d   = S_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          inst_pc_d = pc;
        end
`else
        if (arready) begin
          state_d   = S_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          inst_pc_d = pc;
        end
`endif
      end

      S_DATA: begin
        if (rvalid) begin
          state_d       = S_OUT;
          rready_d      = 1'b0;
          inst_valid_d  = 1'b1;
          inst_d        = rdata;
          fault_d       = 1'b0;
          fault_cause_d = 1'b0;
`ifdef IFU_FAULT_EN
          if (rresp != RESP_OKAY) begin
            inst_d        = '0;
            fault_d       = 1'b1;
            fault_cause_d = CAUSE_BUS_ERR;
          end
`endif
        end
      end

      S_OUT: begin
        if (inst_ready) begin
          state_d       = S_IDLE;
          inst_valid_d  = 1'b0;
          fault_d       = 1'b0;
          fault_cause_d = 1'b0;
        end
      end

      default: begin
        state_d      = S_BOOT;
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      inst_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      inst_valid_q  <= inst_valid_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  assign araddr      = pc;
  assign rready      = rready_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;

`ifdef IFU_FAULT_EN
  // Suppress the request during the one ADDR cycle that discovers a misaligned pc.
  assign arvalid = arvalid_q & ~pc_misaligned(pc[1:0]);
`else
  logic rresp_unused;
  assign rresp_unused = ^rresp;
  assign arvalid      = arvalid_q;
`endif

endmodule
